// File: rtl/calibration_sequencer.sv
// Bit-plane calibration sequencer: shows each LED address bit-plane, waits for the
// camera to settle, then streams one decimated detector sample per cell to the accumulate RAM.
module calibration_sequencer #(
    parameter int NUM_BITS        = 10,
    parameter int NUM_CHANNELS    = 2,
    parameter int DEC_SHIFT       = 2,
    parameter int ACTIVE_H_PIXELS = 320,
    parameter int ACTIVE_LINES    = 180,
    parameter int SETTLE_CYCLES   = 10_000_000,
    parameter int SHOW_TIMEOUT    = 50_000_000,
    parameter int MIRROR_H        = 1,
    localparam int COLS   = ACTIVE_H_PIXELS >> DEC_SHIFT,
    localparam int ROWS   = ACTIVE_LINES >> DEC_SHIFT,
    localparam int ADDR_W = $clog2(COLS * ROWS),
    localparam int BIT_W  = $clog2(NUM_BITS),
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk_pixel,
    input  logic                    rst,
    input  logic                    start_in,
    input  logic                    mode_in,
    input  logic                    abort_in,
    input  logic [CH_W-1:0]         channel_sel_in,
    input  logic [NUM_CHANNELS-1:0] detect_in,
    input  logic [10:0]             hcount_in,
    input  logic [9:0]              vcount_in,
    input  logic                    new_frame_in,
    input  logic                    displayed_frame_valid,
    output logic [BIT_W-1:0]        show_bit_out,
    output logic                    show_req_out,
    output logic                    accum_valid_out,
    output logic [ADDR_W-1:0]       accum_addr_out,
    output logic                    accum_bit_out,
    output logic                    accum_first_out,
    output logic                    busy_out,
    output logic                    done_out,
    output logic                    timeout_out
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SHOW_TIMEOUT) ? SETTLE_CYCLES : SHOW_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SHOW_LAST   = CNT_W'(SHOW_TIMEOUT - 1);
    localparam logic [BIT_W-1:0]  PLANE_LAST  = BIT_W'(NUM_BITS - 1);
    localparam logic [10:0]       H_LIMIT     = 11'(ACTIVE_H_PIXELS);
    localparam logic [9:0]        V_LIMIT     = 10'(ACTIVE_LINES);
    localparam logic [10:0]       H_DEC_MASK  = 11'((1 << DEC_SHIFT) - 1);
    localparam logic [9:0]        V_DEC_MASK  = 10'((1 << DEC_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] COL_LAST    = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);

    typedef enum logic [2:0] {
        IDLE, REQ_SHOW, WAIT_SHOWN, SETTLE, WAIT_NFRAME, CAPTURE
    } state_t;

    state_t           state_q, state_d;
    logic [BIT_W-1:0] plane_q, plane_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;
    logic             start_q, shown_q;
    logic             start_edge, shown_edge;

    assign start_edge = start_in & ~start_q;
    assign shown_edge = displayed_frame_valid & ~shown_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_q   <= IDLE;
            plane_q   <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            chan_q    <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            shown_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            plane_q   <= plane_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            chan_q    <= chan_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            start_q   <= start_in;
            shown_q   <= displayed_frame_valid;
        end
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        plane_d   = plane_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        chan_d    = chan_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        if (abort_in) begin
            state_d = IDLE;
            plane_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (start_edge) begin
                    state_d   = REQ_SHOW;
                    timeout_d = 1'b0;
                    mode_d    = mode_in;
                    chan_d    = channel_sel_in;
                end
                REQ_SHOW: begin
                    state_d = WAIT_SHOWN;
                    cnt_d   = '0;
                end
                WAIT_SHOWN: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        plane_d   = '0;
                    end else if (shown_edge) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = WAIT_NFRAME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_NFRAME: if (new_frame_in) state_d = CAPTURE;
                CAPTURE: if (new_frame_in) begin
                    if (plane_q == PLANE_LAST) begin
                        state_d = IDLE;
                        plane_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                        state_d = mode_q ? REQ_SHOW : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // One sample per decimation block inside the active window; the frame-ending cycle is excluded.
    logic              sample;
    logic [ADDR_W-1:0] row, col, col_eff;

    always_comb begin
        sample = (state_q == CAPTURE) && !new_frame_in && !abort_in &&
                 (hcount_in < H_LIMIT) && (vcount_in < V_LIMIT) &&
                 ((hcount_in & H_DEC_MASK) == '0) && ((vcount_in & V_DEC_MASK) == '0);
        row     = ADDR_W'(vcount_in >> DEC_SHIFT);
        col     = ADDR_W'(hcount_in >> DEC_SHIFT);
        col_eff = (MIRROR_H != 0) ? (COL_LAST - col) : col;
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            accum_valid_out <= 1'b0;
            accum_addr_out  <= '0;
            accum_bit_out   <= 1'b0;
            accum_first_out <= 1'b0;
        end else begin
            accum_valid_out <= sample;
            if (sample) begin
                accum_addr_out  <= row * COLS_A + col_eff;
                accum_bit_out   <= detect_in[chan_q];
                accum_first_out <= (plane_q == '0);
            end
        end
    end

    assign show_bit_out = PLANE_LAST - plane_q;
    assign show_req_out = (state_q == REQ_SHOW);
    assign busy_out     = (state_q != IDLE);
    assign done_out     = done_q;
    assign timeout_out  = timeout_q;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Directed bench for calibration_sequencer: small-window sweep, step, timeout, abort,
// edge-qualification and a second non-mirrored instance for addressing.
module tb_calibration_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0, start2 = 1'b0;
    logic       mode = 1'b0;
    logic [0:0] chan = 1'b0;
    logic       abort = 1'b0, abort2 = 1'b0;
    logic [1:0] detect = '0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic       new_frame = 1'b0;
    logic       auto_show = 1'b0;
    logic       dfv_auto = 1'b0, dfv_man = 1'b0, dfv2 = 1'b0;
    logic       dfv;
    assign dfv = auto_show ? dfv_auto : dfv_man;

    logic [1:0] show_bit, show_bit2;
    logic       show_req, show_req2;
    logic       accum_valid, accum_valid2;
    logic [2:0] accum_addr;
    logic [5:0] accum_addr2;
    logic       accum_bit, accum_bit2, accum_first, accum_first2;
    logic       busy, busy2, done, done2, timeout, timeout2;

    calibration_sequencer #(
        .NUM_BITS(3), .NUM_CHANNELS(2), .DEC_SHIFT(2), .ACTIVE_H_PIXELS(16), .ACTIVE_LINES(8),
        .SETTLE_CYCLES(4), .SHOW_TIMEOUT(20), .MIRROR_H(1)
    ) dut (
        .clk_pixel(clk), .rst(rst), .start_in(start), .mode_in(mode), .abort_in(abort),
        .channel_sel_in(chan), .detect_in(detect), .hcount_in(hcount), .vcount_in(vcount),
        .new_frame_in(new_frame), .displayed_frame_valid(dfv),
        .show_bit_out(show_bit), .show_req_out(show_req), .accum_valid_out(accum_valid),
        .accum_addr_out(accum_addr), .accum_bit_out(accum_bit), .accum_first_out(accum_first),
        .busy_out(busy), .done_out(done), .timeout_out(timeout)
    );

    calibration_sequencer #(
        .NUM_BITS(3), .NUM_CHANNELS(2), .DEC_SHIFT(1), .ACTIVE_H_PIXELS(16), .ACTIVE_LINES(16),
        .SETTLE_CYCLES(4), .SHOW_TIMEOUT(20), .MIRROR_H(0)
    ) dut2 (
        .clk_pixel(clk), .rst(rst), .start_in(start2), .mode_in(mode), .abort_in(abort2),
        .channel_sel_in(chan), .detect_in(detect), .hcount_in(hcount), .vcount_in(vcount),
        .new_frame_in(new_frame), .displayed_frame_valid(dfv2),
        .show_bit_out(show_bit2), .show_req_out(show_req2), .accum_valid_out(accum_valid2),
        .accum_addr_out(accum_addr2), .accum_bit_out(accum_bit2), .accum_first_out(accum_first2),
        .busy_out(busy2), .done_out(done2), .timeout_out(timeout2)
    );

    // Camera: 20x18 raster, new_frame on the last blank pixel, detectors at two fixed pixels.
    localparam int H_TOTAL = 20;
    localparam int V_TOTAL = 18;
    initial forever begin
        @(negedge clk);
        if (int'(hcount) == H_TOTAL - 1) begin
            hcount = '0;
            vcount = (int'(vcount) == V_TOTAL - 1) ? '0 : vcount + 1'b1;
        end else begin
            hcount = hcount + 1'b1;
        end
        new_frame = (int'(hcount) == H_TOTAL - 1) && (int'(vcount) == V_TOTAL - 1);
        detect[1] = (hcount == 11'd0) && (vcount == 10'd4);
        detect[0] = (hcount == 11'd4) && (vcount == 10'd0);
    end

    // LED shower model: answers each show request with a low->high displayed_frame_valid.
    initial forever begin
        @(negedge clk);
        if (auto_show && show_req) begin
            dfv_auto = 1'b0;
            repeat (2) @(negedge clk);
            dfv_auto = 1'b1;
            repeat (2) @(negedge clk);
            dfv_auto = 1'b0;
        end
    end

    typedef struct {
        int pix;
        int addr;
        int bitv;
        int first;
    } sample_t;

    sample_t q1[$];
    sample_t q2[$];
    int      q_show[$];
    int      done_cnt = 0;

    // Output monitor, 1 time unit after the active edge; the camera inputs still hold the sampled pixel.
    initial forever begin
        sample_t s;
        @(posedge clk);
        #1;
        if (accum_valid) begin
            s.pix = int'(hcount) + 32 * int'(vcount);
            s.addr = int'(accum_addr); s.bitv = int'(accum_bit); s.first = int'(accum_first);
            q1.push_back(s);
        end
        if (accum_valid2) begin
            s.pix = int'(hcount) + 32 * int'(vcount);
            s.addr = int'(accum_addr2); s.bitv = int'(accum_bit2); s.first = int'(accum_first2);
            q2.push_back(s);
        end
        if (done) done_cnt++;
        if (show_req) q_show.push_back(int'(show_bit));
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic m);
        mode  = m;
        chan  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    task automatic wait_samples(input int count, input int budget);
        int n = 0;
        while (q1.size() < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sample_wait_bound", int'(q1.size() >= count), 1);
    endtask

    typedef struct {
        int h;
        int v;
        int addr;
        int bitv;
    } vec_t;

    vec_t tab[8];
    int   base, sbase, dbase, n, sz;

    initial begin
        // Expected per-plane sample stream: pixel -> mirrored address and channel-1 detection.
        tab[0] = '{0, 0, 3, 0};  tab[1] = '{4, 0, 2, 0};
        tab[2] = '{8, 0, 1, 0};  tab[3] = '{12, 0, 0, 0};
        tab[4] = '{0, 4, 7, 1};  tab[5] = '{4, 4, 6, 0};
        tab[6] = '{8, 4, 5, 0};  tab[7] = '{12, 4, 4, 0};

        // Reset, with start held high through it so the edge is discarded.
        start = 1'b1;
        cyc(3);
        check("rst_show_bit", int'(show_bit), 2);
        check("rst_busy", int'(busy), 0);
        check("rst_show_req", int'(show_req), 0);
        check("rst_valid", int'(accum_valid), 0);
        check("rst_addr", int'(accum_addr), 0);
        check("rst_done", int'(done), 0);
        check("rst_timeout", int'(timeout), 0);
        rst = 1'b0;
        start = 1'b0;
        cyc(3);
        check("rst_start_discarded", int'(busy), 0);

        // Sweep through all three planes on channel 1.
        auto_show = 1'b1;
        base = q1.size(); sbase = q_show.size(); dbase = done_cnt;
        pulse_start(1'b1);
        check("sweep_busy", int'(busy), 1);
        check("sweep_req_latency", int'(show_req), 1);
        wait_idle("sweep_idle_bound", 6000);
        cyc(2);
        check("sweep_req_count", q_show.size() - sbase, 3);
        for (int p = 0; p < 3; p++) check("sweep_show_bit", q_show[sbase + p], 2 - p);
        check("sweep_samples", q1.size() - base, 24);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 8; k++) begin
                sample_t s;
                s = q1[base + p * 8 + k];
                check("sweep_pixel", s.pix, tab[k].h + 32 * tab[k].v);
                check("sweep_addr", s.addr, tab[k].addr);
                check("sweep_bit", s.bitv, tab[k].bitv);
                check("sweep_first", s.first, (p == 0) ? 1 : 0);
            end
        end
        check("sweep_done_once", done_cnt - dbase, 1);
        check("sweep_end_show_bit", int'(show_bit), 2);

        // Step mode: one plane per start edge, idle between planes.
        base = q1.size(); dbase = done_cnt;
        for (int i = 0; i < 3; i++) begin
            pulse_start(1'b0);
            check("step_busy", int'(busy), 1);
            wait_idle("step_idle_bound", 3000);
            cyc(30);
            check("step_idle_between", int'(busy), 0);
            check("step_show_bit", int'(show_bit), (i == 0) ? 1 : (i == 1) ? 0 : 2);
            check("step_done", done_cnt - dbase, (i == 2) ? 1 : 0);
        end
        check("step_samples", q1.size() - base, 24);
        for (int k = 0; k < 24; k++) check("step_first", q1[base + k].first, (k < 8) ? 1 : 0);

        // Timeout in plane 1: complete plane 0, then never show the pattern.
        pulse_start(1'b0);
        wait_idle("to_plane0_bound", 3000);
        auto_show = 1'b0;
        cyc(2);
        pulse_start(1'b0);
        @(negedge clk);
        n = 0;
        while (!timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, 20);
        check("timeout_busy", int'(busy), 0);
        check("timeout_plane_reset", int'(show_bit), 2);
        pulse_start(1'b0);
        check("timeout_cleared", int'(timeout), 0);
        do_abort();

        // Abort mid-capture in plane 1 of a sweep.
        auto_show = 1'b1;
        cyc(5);
        base = q1.size(); dbase = done_cnt;
        pulse_start(1'b1);
        wait_samples(base + 11, 3000);
        do_abort();
        check("abort_valid", int'(accum_valid), 0);
        check("abort_busy", int'(busy), 0);
        sz = q1.size();
        cyc(800);
        check("abort_stream_stopped", q1.size(), sz);
        check("abort_no_done", done_cnt - dbase, 0);
        pulse_start(1'b0);
        check("abort_restart_req", int'(show_req), 1);
        check("abort_restart_bit", int'(show_bit), 2);
        do_abort();
        cyc(10);

        // displayed_frame_valid already high: only a fresh low->high edge may advance.
        auto_show = 1'b0;
        dfv_man = 1'b1;
        cyc(2);
        pulse_start(1'b1);
        cyc(25);
        check("level_not_edge_timeout", int'(timeout), 1);
        check("level_not_edge_busy", int'(busy), 0);
        pulse_start(1'b1);
        check("level_restart_clears", int'(timeout), 0);
        cyc(5);
        dfv_man = 1'b0;
        cyc(1);
        dfv_man = 1'b1;
        cyc(30);
        check("edge_advances_timeout", int'(timeout), 0);
        check("edge_advances_busy", int'(busy), 1);
        do_abort();
        dfv_man = 1'b0;
        cyc(5);

        // Non-mirrored, DEC_SHIFT=1, 16x16 window instance.
        mode = 1'b0;
        chan = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("dut2_req", int'(show_req2), 1);
        cyc(3);
        dfv2 = 1'b1;
        n = 0;
        while (busy2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("dut2_idle_bound", int'(busy2), 0);
        check("dut2_count", q2.size(), 64);
        check("dut2_pix9", q2[9].pix, 2 + 32 * 2);
        check("dut2_addr9", q2[9].addr, 9);
        check("dut2_addr16", q2[16].addr, 16);
        check("dut2_bit16", q2[16].bitv, 1);
        check("dut2_bit2", q2[2].bitv, 0);
        check("dut2_first", q2[0].first, 1);
        check("dut2_addr63", q2[63].addr, 63);
        check("dut2_show_bit", int'(show_bit2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
